// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb4_1.sv
// Four-requester round-robin arbiter with registered one-hot grants and a one-cycle gap between owners.
// Define GF180MCU_FD_SC_RRARB_TIMEOUT_EN to enable the MAXHOLD hold-timeout watchdog and the TOUT pulse.
module gf180mcu_fd_sc_mcu7t5v0__rrarb4_1 #(
   parameter int MAXHOLD = 15,
   parameter int CW      = 8
) (
   input  logic       CLK,
   input  logic       RN,
   input  logic [3:0] REQ,
   input  logic       DONE,
   output logic [3:0] GNT,
   output logic [1:0] GID,
   output logic       BUSY,
   output logic       TOUT
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t     state;
   logic [1:0] ptr;
   logic       win_vld;
   logic [1:0] win_idx;
   logic [1:0] cand;
   logic       rel_natural;
   logic       rel;

   // Scan from the farthest offset down so the nearest requester after ptr is kept.
   always_comb begin
      win_vld = 1'b0;
      win_idx = ptr;
      cand    = ptr;
      for (int i = 3; i >= 0; i--) begin
         cand = ptr + 2'(i);
         if (REQ[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   assign rel_natural = DONE || !REQ[GID];

`ifdef GF180MCU_FD_SC_RRARB_TIMEOUT_EN
   logic [CW-1:0] cnt;
   logic          hit;

   assign hit = (cnt == CW'(MAXHOLD - 1));
   assign rel = rel_natural || hit;
`else
   logic unused_cfg;

   assign unused_cfg = (MAXHOLD > 0) ^ (CW > 0);
   assign rel        = rel_natural;
   assign TOUT       = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state <= IDLE;
         ptr   <= 2'd0;
         GNT   <= 4'b0000;
         GID   <= 2'd0;
         BUSY  <= 1'b0;
`ifdef GF180MCU_FD_SC_RRARB_TIMEOUT_EN
         cnt   <= '0;
         TOUT  <= 1'b0;
`endif
      end else begin
`ifdef GF180MCU_FD_SC_RRARB_TIMEOUT_EN
         TOUT <= 1'b0;
`endif
         case (state)
            IDLE, GAP: begin
               if (win_vld) begin
                  GNT   <= 4'b0001 << win_idx;
                  GID   <= win_idx;
                  BUSY  <= 1'b1;
                  ptr   <= win_idx + 2'd1;
                  state <= OWN;
`ifdef GF180MCU_FD_SC_RRARB_TIMEOUT_EN
                  cnt   <= '0;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            OWN: begin
               if (rel) begin
                  GNT   <= 4'b0000;
                  BUSY  <= 1'b0;
                  state <= GAP;
`ifdef GF180MCU_FD_SC_RRARB_TIMEOUT_EN
                  // A voluntary release in the same cycle as the timeout is not a forced one.
                  TOUT  <= hit && !rel_natural;
`endif
               end
`ifdef GF180MCU_FD_SC_RRARB_TIMEOUT_EN
               else if (cnt != {CW{1'b1}}) begin
                  cnt <= cnt + CW'(1);
               end
`endif
            end
            default: begin
               state <= IDLE;
               GNT   <= 4'b0000;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule
